// File: rtl/board_ctrl_2048.sv
// 2048 game-state controller: 4x4 tile exponents, line-per-cycle slide/merge,
// LFSR-driven tile spawn, and win / game-over evaluation for the LED matrix.
module board_ctrl_2048 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        clear,
  input  logic        load_valid,
  input  logic [63:0] load_board,
  output logic [63:0] mat_flat,
  output logic [15:0] score,
  output logic        busy,
  output logic        done,
  output logic        moved,
  output logic        win,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LINE,
    S_SPAWN,
    S_CHECK
  } state_t;

  state_t      r_state, w_next;

  logic [63:0] r_board;
  logic [15:0] r_score;
  logic [15:0] r_lfsr;
  logic [1:0]  r_k;
  logic [1:0]  r_dir;
  logic        r_moved;
  logic        r_done;
  logic        r_win;
  logic        r_over;
  logic [3:0]  r_probe;
  logic [3:0]  r_probe_cnt;
  logic        r_spawn_more;
  logic        r_from_move;

  logic        w_accept;
  logic        w_fb;

  // Line datapath: cells listed front (destination edge) to back
  logic [3:0]  w_idx [4];
  logic [3:0]  w_in  [4];
  logic [3:0]  w_cmp [5];
  logic [3:0]  w_out [4];
  logic [2:0]  w_n;
  logic [2:0]  w_o;
  logic        w_skip;
  logic [17:0] w_line_pts;
  logic        w_line_chg;
  logic [17:0] w_score_sum;
  logic [15:0] w_score_next;

  logic [3:0]  w_cell [16];
  logic        w_win;
  logic        w_any_empty;
  logic        w_adj_eq;
  logic        w_probe_empty;
  logic [3:0]  w_spawn_val;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin : line_eval
    w_n        = '0;
    w_o        = '0;
    w_skip     = 1'b0;
    w_line_pts = '0;
    w_line_chg = 1'b0;
    for (int unsigned t = 0; t < 4; t++) begin
      case (r_dir)
        2'd0:    w_idx[t] = {2'(t), r_k};
        2'd1:    w_idx[t] = {~2'(t), r_k};
        2'd2:    w_idx[t] = {r_k, 2'(t)};
        default: w_idx[t] = {r_k, ~2'(t)};
      endcase
      w_in[t]  = r_board[{w_idx[t], 2'b00} +: 4];
      w_out[t] = '0;
    end
    for (int unsigned t = 0; t < 5; t++) begin
      w_cmp[t] = '0;
    end
    for (int unsigned t = 0; t < 4; t++) begin
      if (w_in[t] != '0) begin
        w_cmp[w_n] = w_in[t];
        w_n        = w_n + 3'd1;
      end
    end
    // w_cmp[4] stays zero so the last slot never pairs with a phantom tile
    for (int unsigned t = 0; t < 4; t++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_cmp[t] != '0 && w_cmp[t] == w_cmp[t+1]) begin
        w_out[w_o[1:0]] = (w_cmp[t] == 4'hF) ? 4'hF : w_cmp[t] + 4'd1;
        w_line_pts      = w_line_pts + (18'd1 << ({1'b0, w_cmp[t]} + 5'd1));
        w_skip          = 1'b1;
        w_o             = w_o + 3'd1;
      end else if (w_cmp[t] != '0) begin
        w_out[w_o[1:0]] = w_cmp[t];
        w_o             = w_o + 3'd1;
      end
    end
    for (int unsigned t = 0; t < 4; t++) begin
      if (w_out[t] != w_in[t]) begin
        w_line_chg = 1'b1;
      end
    end
  end

  assign w_score_sum  = {2'b00, r_score} + w_line_pts;
  assign w_score_next = (w_score_sum[17:16] != 2'b00) ? 16'hFFFF : w_score_sum[15:0];

  always_comb begin : board_eval
    w_win       = 1'b0;
    w_any_empty = 1'b0;
    w_adj_eq    = 1'b0;
    for (int unsigned c = 0; c < 16; c++) begin
      w_cell[c] = r_board[4*c +: 4];
      if (w_cell[c] >= 4'd11) begin
        w_win = 1'b1;
      end
      if (w_cell[c] == '0) begin
        w_any_empty = 1'b1;
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        if (w_cell[4*i+j] == w_cell[4*i+j+1]) begin
          w_adj_eq = 1'b1;
        end
        if (w_cell[4*j+i] == w_cell[4*j+i+4]) begin
          w_adj_eq = 1'b1;
        end
      end
    end
  end

  assign w_probe_empty = (w_cell[r_probe] == '0);
  assign w_spawn_val   = (r_lfsr[3:0] == 4'd0) ? 4'd2 : 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin : next_state
    w_next     = r_state;
    w_accept   = 1'b0;
    busy       = (r_state != S_IDLE);
    move_ready = (r_state == S_IDLE) && !r_over;
    if (clear) begin
      w_next = S_INIT;
    end else if (load_valid) begin
      w_next = S_CHECK;
    end else begin
      case (r_state)
        S_INIT: w_next = S_SPAWN;
        S_IDLE: begin
          if (move_valid && !r_over) begin
            w_next   = S_LINE;
            w_accept = 1'b1;
          end
        end
        S_LINE: begin
          if (r_k == 2'd3) begin
            w_next = (r_moved || w_line_chg) ? S_SPAWN : S_IDLE;
          end
        end
        S_SPAWN: begin
          if (w_probe_empty) begin
            w_next = r_spawn_more ? S_SPAWN : S_CHECK;
          end else if (r_probe_cnt == 4'd15) begin
            w_next = S_CHECK;
          end
        end
        S_CHECK: w_next = S_IDLE;
        default: w_next = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board      <= '0;
      r_score      <= '0;
      r_lfsr       <= SEED;
      r_k          <= '0;
      r_dir        <= '0;
      r_moved      <= 1'b0;
      r_done       <= 1'b0;
      r_win        <= 1'b0;
      r_over       <= 1'b0;
      r_probe      <= '0;
      r_probe_cnt  <= '0;
      r_spawn_more <= 1'b0;
      r_from_move  <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      r_done <= 1'b0;
      if (clear) begin
        r_win       <= 1'b0;
        r_over      <= 1'b0;
        r_moved     <= 1'b0;
        r_from_move <= 1'b0;
      end else if (load_valid) begin
        // win is rebuilt from the loaded board in the following CHECK cycle
        r_board     <= load_board;
        r_win       <= 1'b0;
        r_from_move <= 1'b0;
      end else begin
        case (r_state)
          S_INIT: begin
            r_board      <= '0;
            r_score      <= '0;
            r_probe      <= r_lfsr[7:4];
            r_probe_cnt  <= '0;
            r_spawn_more <= 1'b1;
            r_from_move  <= 1'b0;
          end
          S_IDLE: begin
            if (w_accept) begin
              r_dir       <= move_dir;
              r_k         <= '0;
              r_moved     <= 1'b0;
              r_from_move <= 1'b1;
            end
          end
          S_LINE: begin
            for (int unsigned t = 0; t < 4; t++) begin
              r_board[{w_idx[t], 2'b00} +: 4] <= w_out[t];
            end
            r_score <= w_score_next;
            r_moved <= r_moved | w_line_chg;
            r_k     <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              if (!(r_moved || w_line_chg)) begin
                r_done <= 1'b1;
              end else begin
                r_probe      <= r_lfsr[7:4];
                r_probe_cnt  <= '0;
                r_spawn_more <= 1'b0;
              end
            end
          end
          S_SPAWN: begin
            if (w_probe_empty) begin
              r_board[{r_probe, 2'b00} +: 4] <= w_spawn_val;
              if (r_spawn_more) begin
                r_spawn_more <= 1'b0;
                r_probe      <= r_lfsr[7:4];
                r_probe_cnt  <= '0;
              end
            end else begin
              r_probe     <= r_probe + 4'd1;
              r_probe_cnt <= r_probe_cnt + 4'd1;
            end
          end
          S_CHECK: begin
            r_win  <= r_win | w_win;
            r_over <= !w_any_empty && !w_adj_eq;
            r_done <= r_from_move;
          end
          default: ;
        endcase
      end
    end
  end

  assign mat_flat  = r_board;
  assign score     = r_score;
  assign done      = r_done;
  assign moved     = r_moved;
  assign win       = r_win;
  assign game_over = r_over;

endmodule

// File: tb/tb_board_ctrl_2048.sv
// Self-checking bench for board_ctrl_2048: directed scenarios plus randomized
// boards compared against a queue-based slide/merge reference model.
module tb_board_ctrl_2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_board = '0;
  logic [63:0] mat_flat;
  logic [15:0] score;
  logic        busy;
  logic        done;
  logic        moved;
  logic        win;
  logic        game_over;

  board_ctrl_2048 #(.SEED(16'hACE1)) dut (
    .clk        (clk),
    .reset      (reset),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .clear      (clear),
    .load_valid (load_valid),
    .load_board (load_board),
    .mat_flat   (mat_flat),
    .score      (score),
    .busy       (busy),
    .done       (done),
    .moved      (moved),
    .win        (win),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  typedef int brd_t [16];

  int tests = 0;
  int fails = 0;
  int exp_score = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic brd_t unpack(input logic [63:0] f);
    brd_t b;
    for (int c = 0; c < 16; c++) b[c] = int'(f[4*c +: 4]);
    return b;
  endfunction

  function automatic logic [63:0] pack(input brd_t b);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < 16; c++) f[4*c +: 4] = 4'(b[c]);
    return f;
  endfunction

  // Reference: gather each line from the destination edge, then merge greedily with queues
  task automatic model_move(input brd_t b, input int dir, output brd_t r, output longint pts);
    r   = b;
    pts = 0;
    for (int k = 0; k < 4; k++) begin
      int cells [4];
      int q [$];
      int m [$];
      int v;
      for (int t = 0; t < 4; t++) begin
        int i, j;
        case (dir)
          0:       begin i = t;     j = k;     end
          1:       begin i = 3 - t; j = k;     end
          2:       begin i = k;     j = t;     end
          default: begin i = k;     j = 3 - t; end
        endcase
        cells[t] = 4 * i + j;
        if (b[cells[t]] != 0) q.push_back(b[cells[t]]);
      end
      while (q.size() > 0) begin
        if (q.size() >= 2 && q[0] == q[1]) begin
          v = q[0];
          m.push_back((v + 1 > 15) ? 15 : v + 1);
          pts += longint'(1) << (v + 1);
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          m.push_back(q.pop_front());
        end
      end
      for (int t = 0; t < 4; t++) r[cells[t]] = (t < m.size()) ? m[t] : 0;
    end
  endtask

  task automatic do_load(input string tag, input logic [63:0] v);
    int n;
    bit saw_done;
    load_valid = 1'b1;
    load_board = v;
    @(negedge clk);
    load_valid = 1'b0;
    n = 0;
    saw_done = 0;
    while (busy !== 1'b0 && n < 8) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
      n++;
    end
    chk({tag, "_load_idle"}, busy, 0);
    chk({tag, "_load_no_done"}, saw_done, 0);
    chk({tag, "_load_board"}, mat_flat, v);
  endtask

  task automatic do_move(input int dir, output int cyc, output logic mv);
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    @(negedge clk);
    move_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    mv = moved;
  endtask

  // Move a loaded board, compare to the model; exactly one spawn is tolerated when it moved
  task automatic run_move(input string tag, input logic [63:0] start, input int dir);
    brd_t b, e, d;
    longint pts;
    bit exp_moved;
    int cyc, diffs, bad;
    logic mv;
    do_load(tag, start);
    b = unpack(start);
    model_move(b, dir, e, pts);
    exp_moved = (pack(e) != start);
    exp_score = (exp_score + pts > 65535) ? 65535 : int'(exp_score + pts);
    chk({tag, "_ready"}, move_ready, 1);
    do_move(dir, cyc, mv);
    d = unpack(mat_flat);
    diffs = 0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (d[c] != e[c]) begin
        diffs++;
        if (e[c] != 0 || !(d[c] == 1 || d[c] == 2)) bad++;
      end
    end
    chk({tag, "_moved"}, mv, exp_moved);
    chk({tag, "_score"}, score, exp_score);
    if (exp_moved) begin
      chk({tag, "_latency_6_21"}, (cyc >= 6 && cyc <= 21), 1);
      chk({tag, "_spawn_count"}, diffs, 1);
      chk({tag, "_spawn_cell"}, bad, 0);
    end else begin
      chk({tag, "_latency_4"}, cyc, 4);
      chk({tag, "_board_same"}, diffs, 0);
    end
  endtask

  task automatic wait_init(input string tag);
    int n, tiles, bad;
    brd_t d;
    n = 0;
    while (move_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_within_34"}, (n <= 34), 1);
    d = unpack(mat_flat);
    tiles = 0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (d[c] != 0) begin
        tiles++;
        if (d[c] != 1 && d[c] != 2) bad++;
      end
    end
    chk({tag, "_two_tiles"}, tiles, 2);
    chk({tag, "_tile_vals"}, bad, 0);
    chk({tag, "_score0"}, score, 0);
    chk({tag, "_not_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    brd_t cb;
    logic [63:0] snap;
    bit saw;

    repeat (2) @(negedge clk);
    chk("rst_mat", mat_flat, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", move_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_moved", moved, 0);
    chk("rst_win", win, 0);
    chk("rst_over", game_over, 0);
    reset = 1'b0;
    wait_init("init");
    exp_score = 0;

    run_move("dmerge", 64'h0000_0000_0000_1111, 2);
    chk("dmerge_c0", mat_flat[3:0], 4'd2);
    chk("dmerge_c1", mat_flat[7:4], 4'd2);

    run_move("nochain", 64'h0000_0000_0000_2101, 2);
    chk("nochain_c0", mat_flat[3:0], 4'd2);
    chk("nochain_c1", mat_flat[7:4], 4'd2);

    run_move("nochange", 64'h0000_0000_0000_0021, 2);
    chk("nochange_board", mat_flat, 64'h0000_0000_0000_0021);

    run_move("win", 64'h0000_0000_000A_000A, 0);
    chk("win_cell00", mat_flat[3:0], 4'd11);
    chk("win_flag", win, 1);
    begin
      int cyc;
      logic mv;
      brd_t e;
      longint pts;
      model_move(unpack(mat_flat), 3, e, pts);
      exp_score = (exp_score + pts > 65535) ? 65535 : int'(exp_score + pts);
      do_move(3, cyc, mv);
      chk("win_sticky", win, 1);
      chk("win_sticky_score", score, exp_score);
    end

    for (int it = 0; it < 25; it++) begin
      brd_t rb;
      for (int c = 0; c < 16; c++)
        rb[c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
      rb[$urandom_range(0, 15)] = 0;
      run_move($sformatf("rnd%0d", it), pack(rb), int'($urandom_range(0, 3)));
    end

    run_move("sat", 64'h0000_0000_0000_00FF, 2);
    chk("sat_cell", mat_flat[3:0], 4'd15);
    chk("sat_score", score, 16'hFFFF);

    for (int c = 0; c < 16; c++) cb[c] = (((c / 4) + (c % 4)) % 2 == 0) ? 1 : 2;
    do_load("over", pack(cb));
    chk("over_flag", game_over, 1);
    chk("over_ready", move_ready, 0);
    snap = mat_flat;
    move_valid = 1'b1;
    move_dir = 2'd2;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) saw = 1;
    end
    move_valid = 1'b0;
    chk("over_ignored", saw, 0);
    chk("over_board", mat_flat, snap);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_over", game_over, 0);
    chk("clear_win", win, 0);
    wait_init("clear");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
